// File: rtl/mux_4_1_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_4_1_if
// Purpose  : Bundles the operand/select inputs and the result outputs of the
//            mux_4_1 operation selector.
// Signals  : in_valid  - operands/select valid this cycle
//            select    - 2-bit operation select (00 AND, 01 OR, 10 ADD, 11 XOR)
//            a, b      - 5-bit unsigned operands
//            sum       - 5-bit selected result
//            carry_out - carry from the ADD path, 0 for other selects
//            out_valid - sum/carry_out valid
// Modports : master drives operands and receives results; slave is the
//            selector side.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_4_1_if;
  logic       in_valid;
  logic [1:0] select;
  logic [4:0] a;
  logic [4:0] b;
  logic [4:0] sum;
  logic       carry_out;
  logic       out_valid;

  modport master (
    output in_valid, select, a, b,
    input  sum, carry_out, out_valid
  );

  modport slave (
    input  in_valid, select, a, b,
    output sum, carry_out, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : mux_4_1
// Purpose  : 5-bit four-way operation selector. AND, OR, ADD and XOR of the
//            two operands are computed in parallel and a 4:1 mux picks one.
//            carry_out carries the ADD overflow bit and is 0 otherwise.
// Build    : MUX_4_1_OUTREG_EN defined   -> outputs registered, 1-cycle
//                                           latency, async active-low clear.
//            MUX_4_1_OUTREG_EN undefined -> purely combinational, zero
//                                           latency; clk/rst_n unused.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous reset, active low
//            bus   - mux_4_1_if slave modport (in_valid, select, a, b,
//                    sum, carry_out, out_valid)
// Revision : 1.0 - initial release
// ============================================================================
module mux_4_1 (
  input  wire logic clk,
  input  wire logic rst_n,
  mux_4_1_if.slave  bus
);

  logic [4:0] w_and;
  logic [4:0] w_or;
  logic [4:0] w_xor;
  logic [5:0] w_add;
  logic [4:0] w_sum;
  logic       w_carry;

  assign w_and = bus.a & bus.b;
  assign w_or  = bus.a | bus.b;
  assign w_xor = bus.a ^ bus.b;
  // Zero-extend both operands so bit 5 holds the carry.
  assign w_add = {1'b0, bus.a} + {1'b0, bus.b};

  // Any select that is not a clean 00..11 (X/Z included) lands in the
  // default branch and yields the AND result with no carry.
  always_comb begin
    w_sum   = w_and;
    w_carry = 1'b0;
    case (bus.select)
      2'b00: begin
        w_sum   = w_and;
        w_carry = 1'b0;
      end
      2'b01: begin
        w_sum   = w_or;
        w_carry = 1'b0;
      end
      2'b10: begin
        w_sum   = w_add[4:0];
        w_carry = w_add[5];
      end
      2'b11: begin
        w_sum   = w_xor;
        w_carry = 1'b0;
      end
      default: begin
        w_sum   = w_and;
        w_carry = 1'b0;
      end
    endcase
  end

`ifdef MUX_4_1_OUTREG_EN
  logic [4:0] r_sum;
  logic       r_carry;
  logic       r_valid;

  // Data is captured every cycle; in_valid only travels alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= 5'b00000;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_carry <= w_carry;
      r_valid <= bus.in_valid;
    end
  end

  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carry;
  assign bus.out_valid = r_valid;
`else
  // Clock and reset have no role in the combinational build.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst_n;

  assign bus.sum       = w_sum;
  assign bus.carry_out = w_carry;
  assign bus.out_valid = bus.in_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4_1
// Purpose  : Self-checking bench for mux_4_1 in either build. Expected
//            results come from an arithmetic reference model; latency
//            handling follows MUX_4_1_OUTREG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4_1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Expected outputs of the previous input (registered build latency check).
  logic [6:0] prev_exp;

  mux_4_1_if bus ();

  mux_4_1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {out_valid, carry_out, sum} from plain integer arithmetic.
  function automatic logic [6:0] model(int sel, int a, int b, bit v);
    int r;
    int c;
    c = 0;
    case (sel)
      0: r = a & b;
      1: r = a | b;
      2: begin
        r = (a + b) % 32;
        c = (a + b) / 32;
      end
      default: r = a ^ b;
    endcase
    return {v, c[0], r[4:0]};
  endfunction

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    got = {bus.out_valid, bus.carry_out, bus.sum};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got(v,c,sum)=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input int a, input int b, input bit v);
    bus.select   = sel[1:0];
    bus.a        = a[4:0];
    bus.b        = b[4:0];
    bus.in_valid = v;
  endtask

  // Apply one input for one clock cycle and check it.
  task automatic step(input string tag, input int sel, input int a, input int b, input bit v);
    logic [6:0] exp;
    exp = model(sel, a, b, v);
    drive(sel, a, b, v);
    #1;
`ifdef MUX_4_1_OUTREG_EN
    check({tag, "_hold"}, prev_exp);
    @(posedge clk);
    #1;
    check(tag, exp);
    prev_exp = exp;
`else
    check(tag, exp);
    @(posedge clk);
    #1;
    check({tag, "_post"}, exp);
`endif
  endtask

  initial begin
    int sel;
    int a;
    int b;
    total    = 0;
    bad      = 0;
    prev_exp = 7'b0;

    // Reset with arbitrary inputs.
    rst_n = 1'b0;
    drive(2, 27, 9, 1'b1);
    #2;
`ifdef MUX_4_1_OUTREG_EN
    check("reset_immediate", 7'b0);
    @(posedge clk);
    #2;
    check("reset_held", 7'b0);
`else
    check("reset_comb", model(2, 27, 9, 1'b1));
    @(posedge clk);
    #2;
`endif
    rst_n = 1'b1;
    prev_exp = 7'b0;
    step("first_after_release", 2, 27, 9, 1'b1);

    // Directed cases, applied back-to-back with in_valid high.
    step("and",          0, 5'b11111, 5'b10001, 1'b1);
    step("or",           1, 5'b00011, 5'b00001, 1'b1);
    step("add_no_ovf",   2, 5'b10101, 5'b01010, 1'b1);
    step("add_ovf",      2, 5'b11111, 5'b00001, 1'b1);
    step("xor_equal",    3, 5'b10110, 5'b10110, 1'b1);
    step("invalid_data", 2, 5'b10000, 5'b10000, 1'b0);
    step("stream_and",   0, 5'b01101, 5'b11011, 1'b1);
    step("stream_or",    1, 5'b01101, 5'b10010, 1'b1);
    step("stream_add",   2, 5'b11001, 5'b01110, 1'b1);
    step("stream_xor",   3, 5'b11001, 5'b01110, 1'b1);

    // Mid-stream reset drops the value in flight.
    drive(2, 31, 31, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
`ifdef MUX_4_1_OUTREG_EN
    check("midreset_async", 7'b0);
    @(posedge clk);
    #1;
    check("midreset_dropped", 7'b0);
`else
    check("midreset_comb", model(2, 31, 31, 1'b1));
    @(posedge clk);
    #1;
`endif
    rst_n = 1'b1;
    prev_exp = 7'b0;
    step("after_midreset", 1, 5'b10100, 5'b00110, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 3));
      a   = int'($urandom_range(0, 31));
      b   = int'($urandom_range(0, 31));
      step("random", sel, a, b, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
